// File: rtl/i8088_bus_responder_if.sv
// 8088 minimum-mode bus signals seen by the responder; AD stays a plain inout port on the
// responder because it is a shared tri-state net.
interface i8088_bus_responder_if;
  logic        ALE;
  logic        IOM;
  logic        RD;
  logic        WR;
  logic [11:0] A;
  logic        READY;
  logic [19:0] Address;
  logic        Selected;

  modport master (
    output ALE, IOM, RD, WR, A,
    input  READY, Address, Selected
  );

  modport slave (
    input  ALE, IOM, RD, WR, A,
    output READY, Address, Selected
  );
endinterface

// File: rtl/i8088_bus_responder.sv
// Byte-array peripheral answering 8088 minimum-mode bus cycles in a decoded window.
// Define I8088_RESP_WAIT_EN to build the WAIT state / READY wait-state counter.
module i8088_bus_responder #(
  parameter logic [19:0] BASE_ADDR   = 20'h00000,
  parameter int          ADDR_BITS   = 10,
  parameter bit          IO_SPACE    = 1'b0,
  parameter int          WAIT_STATES = 2
) (
  input  logic                 CLK,
  input  logic                 RESET,
  i8088_bus_responder_if.slave bus,
  inout  wire  [7:0]           AD
);

  localparam int          DEPTH    = 2 ** ADDR_BITS;
  localparam logic [20:0] WIN_SIZE = 21'(DEPTH);

  // state     | meaning
  // S_IDLE    | no cycle in progress
  // S_LATCHED | address latched, waiting for a strobe (or parked if unselected)
  // S_WAIT    | READY low, counting wait states
  // S_DRIVE   | read data driven on AD until RD goes high
  // S_WCAP    | capturing write data until WR goes high
  typedef enum logic [2:0] {
    S_IDLE,
    S_LATCHED,
    S_DRIVE,
    S_WCAP
`ifdef I8088_RESP_WAIT_EN
    , S_WAIT
`endif
  } state_t;

  state_t state, state_n;

  logic [7:0]           mem [0:DEPTH-1];
  logic [19:0]          address_q;
  logic                 selected_q;
  logic [7:0]           ad_q;
  logic                 ad_oe, ad_oe_n;
  logic [7:0]           wdata;
  logic                 ad_load, wcap_en, mem_we, latch;
  logic                 go_data, go_rd;
  logic [19:0]          lat_addr;
  logic [19:0]          lat_diff;
  logic                 sel_calc;
  logic [ADDR_BITS-1:0] offset;

`ifdef I8088_RESP_WAIT_EN
  localparam logic [3:0] WS_LOAD = 4'(WAIT_STATES - 1);
  logic [3:0] cnt, cnt_n;
  logic       ready_q, ready_n;
  logic       rd_cyc, rd_cyc_n;
`endif

  assign lat_addr = {bus.A, AD};
  assign lat_diff = lat_addr - BASE_ADDR;
  assign sel_calc = (bus.IOM == IO_SPACE) && ({1'b0, lat_diff} < WIN_SIZE);
  // Low bits of the difference equal the difference of the low bits.
  assign offset   = address_q[ADDR_BITS-1:0] - BASE_ADDR[ADDR_BITS-1:0];

  always_ff @(posedge CLK) begin
    if (RESET) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n  = state;
    ad_oe_n  = 1'b0;
    ad_load  = 1'b0;
    wcap_en  = 1'b0;
    mem_we   = 1'b0;
    latch    = 1'b0;
    go_data  = 1'b0;
    go_rd    = 1'b0;
`ifdef I8088_RESP_WAIT_EN
    cnt_n    = cnt;
    ready_n  = 1'b1;
    rd_cyc_n = rd_cyc;
`endif
    if (bus.ALE) begin
      state_n = S_LATCHED;
      latch   = 1'b1;
    end else begin
      case (state)
        S_LATCHED: begin
          if (selected_q && (bus.RD ^ bus.WR)) begin
`ifdef I8088_RESP_WAIT_EN
            rd_cyc_n = !bus.RD;
            if (WAIT_STATES == 0) begin
              go_data = 1'b1;
              go_rd   = !bus.RD;
            end else begin
              state_n = S_WAIT;
              cnt_n   = WS_LOAD;
              ready_n = 1'b0;
            end
`else
            go_data = 1'b1;
            go_rd   = !bus.RD;
`endif
          end
        end
`ifdef I8088_RESP_WAIT_EN
        S_WAIT: begin
          if (rd_cyc ? bus.RD : bus.WR) begin
            state_n = S_IDLE;
          end else if (cnt == 4'd0) begin
            go_data = 1'b1;
            go_rd   = rd_cyc;
          end else begin
            cnt_n   = cnt - 4'd1;
            ready_n = 1'b0;
          end
        end
`endif
        S_DRIVE: begin
          if (bus.RD) state_n = S_IDLE;
          else        ad_oe_n = 1'b1;
        end
        S_WCAP: begin
          if (bus.WR) begin
            mem_we  = 1'b1;
            state_n = S_IDLE;
          end else begin
            wcap_en = 1'b1;
          end
        end
        default: ;
      endcase
      if (go_data) begin
        if (go_rd) begin
          state_n = S_DRIVE;
          ad_oe_n = 1'b1;
          ad_load = 1'b1;
        end else begin
          state_n = S_WCAP;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      address_q  <= 20'h0;
      selected_q <= 1'b0;
      ad_q       <= 8'h00;
      ad_oe      <= 1'b0;
      wdata      <= 8'h00;
`ifdef I8088_RESP_WAIT_EN
      cnt        <= 4'd0;
      ready_q    <= 1'b1;
      rd_cyc     <= 1'b0;
`endif
    end else begin
      ad_oe <= ad_oe_n;
      if (latch) begin
        address_q  <= lat_addr;
        selected_q <= sel_calc;
      end
      if (ad_load) ad_q  <= mem[offset];
      if (wcap_en) wdata <= AD;
`ifdef I8088_RESP_WAIT_EN
      cnt     <= cnt_n;
      ready_q <= ready_n;
      rd_cyc  <= rd_cyc_n;
`endif
    end
  end

  // Array is deliberately not reset; a reset edge must also suppress a pending write.
  always_ff @(posedge CLK) begin
    if (mem_we && !RESET) mem[offset] <= wdata;
  end

  assign AD           = ad_oe ? ad_q : 8'hzz;
  assign bus.Address  = address_q;
  assign bus.Selected = selected_q;
`ifdef I8088_RESP_WAIT_EN
  assign bus.READY    = ready_q;
`else
  assign bus.READY    = 1'b1;
`endif

endmodule

// File: tb/tb_i8088_bus_responder.sv
// Directed bench for i8088_bus_responder; AD has a pull-up so a released bus reads 8'hFF.
module tb_i8088_bus_responder;

`ifdef I8088_RESP_WAIT_EN
  localparam int WS_EXP = 2;
`else
  localparam int WS_EXP = 0;
`endif
  localparam int LAT = WS_EXP + 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  i8088_bus_responder_if bus ();
  tri1  [7:0] ad_bus;
  logic [7:0] tb_ad;
  logic       tb_ad_oe;
  assign ad_bus = tb_ad_oe ? tb_ad : 8'hzz;

  int n_cmp = 0;
  int n_err = 0;

  i8088_bus_responder #(
    .BASE_ADDR  (20'h10000),
    .ADDR_BITS  (10),
    .IO_SPACE   (1'b0),
    .WAIT_STATES(2)
  ) dut (
    .CLK  (clk),
    .RESET(rst),
    .bus  (bus),
    .AD   (ad_bus)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_addr(input logic [19:0] addr, input logic iom);
    bus.ALE  = 1'b1;
    bus.IOM  = iom;
    bus.A    = addr[19:8];
    tb_ad    = addr[7:0];
    tb_ad_oe = 1'b1;
    tick();
    bus.ALE  = 1'b0;
    tb_ad_oe = 1'b0;
    #1;
  endtask

  task automatic do_write(input logic [19:0] addr, input logic [7:0] data, input logic iom,
                          input int nlow, output logic sel, output int rdy_low);
    do_addr(addr, iom);
    sel      = bus.Selected;
    rdy_low  = 0;
    bus.WR   = 1'b0;
    tb_ad    = data;
    tb_ad_oe = 1'b1;
    repeat (nlow) begin
      tick();
      if (bus.READY == 1'b0) rdy_low++;
    end
    bus.WR = 1'b1;
    tick();
    tb_ad_oe = 1'b0;
  endtask

  task automatic do_read(input logic [19:0] addr, input logic iom, output logic sel,
                         output logic [7:0] data, output logic [7:0] pre, output logic [7:0] post,
                         output int rdy_low, output int drove);
    rdy_low = 0;
    drove   = 0;
    data    = 8'hFF;
    pre     = 8'hFF;
    do_addr(addr, iom);
    sel    = bus.Selected;
    bus.RD = 1'b0;
    #1;
    for (int i = 0; i <= LAT + 1; i++) begin
      if (i > 0) begin
        tick();
        if (bus.READY == 1'b0) rdy_low++;
      end
      if (ad_bus != 8'hFF) drove++;
      if (i == LAT - 1) pre = ad_bus;
      if (i == LAT) data = ad_bus;
    end
    bus.RD = 1'b1;
    tick();
    post = ad_bus;
  endtask

  task automatic rd_chk(input string tag, input logic [19:0] addr, input logic iom,
                        input logic exp_sel, input logic [7:0] exp_data);
    logic       sel;
    logic [7:0] data, pre, post;
    int         rl, dv;
    do_read(addr, iom, sel, data, pre, post, rl, dv);
    check_val({tag, ".sel"}, 32'(sel), 32'(exp_sel));
    check_val({tag, ".addr"}, 32'(bus.Address), 32'(addr));
    check_val({tag, ".post"}, 32'(post), 32'hFF);
    if (exp_sel) begin
      check_val({tag, ".data"}, 32'(data), 32'(exp_data));
      check_val({tag, ".pre"}, 32'(pre), 32'hFF);
      check_val({tag, ".rdy_low"}, 32'(rl), 32'(WS_EXP));
      check_val({tag, ".drive_cyc"}, 32'(dv), 32'd2);
    end else begin
      check_val({tag, ".rdy_low"}, 32'(rl), 32'd0);
      check_val({tag, ".drive_cyc"}, 32'(dv), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic sel;
    int   rl;

    rst      = 1'b1;
    bus.ALE  = 1'b0;
    bus.IOM  = 1'b0;
    bus.RD   = 1'b1;
    bus.WR   = 1'b1;
    bus.A    = 12'h000;
    tb_ad    = 8'h00;
    tb_ad_oe = 1'b0;
    tick();
    tick();
    check_val("rst.ready", 32'(bus.READY), 32'd1);
    check_val("rst.ad", 32'(ad_bus), 32'hFF);
    check_val("rst.addr", 32'(bus.Address), 32'h0);
    check_val("rst.sel", 32'(bus.Selected), 32'd0);
    rst = 1'b0;
    tick();

    do_write(20'h10004, 8'hA5, 1'b0, 4, sel, rl);
    check_val("wr1.sel", 32'(sel), 32'd1);
    check_val("wr1.rdy_low", 32'(rl), 32'(WS_EXP));
    check_val("wr1.addr", 32'(bus.Address), 32'h10004);
    rd_chk("rd1", 20'h10004, 1'b0, 1'b1, 8'hA5);

    rd_chk("out_lo", 20'h0FFFF, 1'b0, 1'b0, 8'hFF);
    rd_chk("io_space", 20'h10004, 1'b1, 1'b0, 8'hFF);

    do_write(20'h10000, 8'h11, 1'b0, 4, sel, rl);
    check_val("wr_lo.sel", 32'(sel), 32'd1);
    do_write(20'h103FF, 8'h22, 1'b0, 4, sel, rl);
    check_val("wr_hi.sel", 32'(sel), 32'd1);
    rd_chk("edge_lo", 20'h10000, 1'b0, 1'b1, 8'h11);
    rd_chk("edge_hi", 20'h103FF, 1'b0, 1'b1, 8'h22);

    do_write(20'h10400, 8'h33, 1'b0, 4, sel, rl);
    check_val("wr_out.sel", 32'(sel), 32'd0);
    check_val("wr_out.rdy_low", 32'(rl), 32'd0);
    rd_chk("no_alias", 20'h10000, 1'b0, 1'b1, 8'h11);
    rd_chk("out_hi", 20'h10400, 1'b0, 1'b0, 8'hFF);

    // New ALE while a write is waiting must drop the write.
    do_addr(20'h10004, 1'b0);
    bus.WR   = 1'b0;
    tb_ad    = 8'h5A;
    tb_ad_oe = 1'b1;
    tick();
    check_val("ab_ale.ready_mid", 32'(bus.READY), (WS_EXP > 0) ? 32'd0 : 32'd1);
    bus.ALE = 1'b1;
    bus.A   = 12'h100;
    tb_ad   = 8'h10;
    bus.WR  = 1'b1;
    tick();
    check_val("ab_ale.ready", 32'(bus.READY), 32'd1);
    check_val("ab_ale.addr", 32'(bus.Address), 32'h10010);
    bus.ALE  = 1'b0;
    tb_ad_oe = 1'b0;
    tick();
    rd_chk("ab_ale_rb", 20'h10004, 1'b0, 1'b1, 8'hA5);

    // Reset while driving read data.
    do_addr(20'h10000, 1'b0);
    bus.RD = 1'b0;
    repeat (LAT) tick();
    check_val("rst_drv.ad_before", 32'(ad_bus), 32'h11);
    rst = 1'b1;
    tick();
    check_val("rst_drv.ad", 32'(ad_bus), 32'hFF);
    check_val("rst_drv.ready", 32'(bus.READY), 32'd1);
    rst    = 1'b0;
    bus.RD = 1'b1;
    tick();

    // Reset on the edge that would have committed a write.
    do_addr(20'h10004, 1'b0);
    bus.WR   = 1'b0;
    tb_ad    = 8'h77;
    tb_ad_oe = 1'b1;
    repeat (LAT + 2) tick();
    rst    = 1'b1;
    bus.WR = 1'b1;
    tick();
    rst      = 1'b0;
    tb_ad_oe = 1'b0;
    tick();
    rd_chk("rst_wr_rb", 20'h10004, 1'b0, 1'b1, 8'hA5);
    rd_chk("rst_drv_rb", 20'h10000, 1'b0, 1'b1, 8'h11);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/i8088_bus_responder.md
# i8088_bus_responder

Memory-mapped peripheral that sits on the slave side of the Intel 8088 minimum-mode bus and answers the bus cycles the processor model generates. It demultiplexes the address from `AD`/`A` on `ALE`, decodes a configurable address window in memory or I/O space, and serves reads and writes from an internal byte array. It inserts wait states through `READY` and drives `AD` only while it owns a read cycle.

## Interface
- `BASE_ADDR`, 20'h00000: first byte address of the decoded window.
- `ADDR_BITS`, 10: window size is 2^ADDR_BITS bytes. This is also the depth of the internal array.
- `IO_SPACE`, 0: 0 responds to memory cycles (`IOM`=0); 1 responds to I/O cycles (`IOM`=1).
- `WAIT_STATES`, 2: number of cycles `READY` is held low per selected cycle (range 0..15).

Ports:
- `CLK`, input, 1: bus clock. All state changes on the rising edge.
- `RESET`, input, 1: synchronous, active-high reset.
- `ALE`, input, 1: address latch enable from the processor.
- `IOM`, input, 1: 1 = I/O cycle, 0 = memory cycle.
- `RD`, input, 1: read strobe, active low.
- `WR`, input, 1: write strobe, active low.
- `A`, input, 12: upper address bits [19:8].
- `AD`, inout, 8: multiplexed address/data. Driven only in the DRIVE state, high-Z otherwise.
- `READY`, output, 1: wait-state request to the processor. 0 = insert wait.
- `Address`, output, 20: latched bus address, for the peripheral modport and debug.
- `Selected`, output, 1: latched address and `IOM` fall inside this block's window.

## Operation
- **Address latch:** at an edge with `ALE`=1, capture `Address`<={`A`,`AD`}, capture `IOM`, and compute `Selected`.
- **Decode rule:** `Selected` = (`IOM`==`IO_SPACE`) && (`Address` − `BASE_ADDR` < 2^ADDR_BITS), using 20-bit unsigned arithmetic. The array offset is the low `ADDR_BITS` bits of (`Address` − `BASE_ADDR`).
- **States:** IDLE, LATCHED, WAIT, DRIVE, WCAP.
  - IDLE to LATCHED: on `ALE`=1.
  - LATCHED to WAIT: `Selected` and exactly one of `RD`/`WR` sampled low. Goes directly to DRIVE (read) or WCAP (write) when `WAIT_STATES`=0.
  - WAIT: counts down `WAIT_STATES` cycles, then enters DRIVE if the cycle is a read, WCAP if a write.
  - DRIVE: `AD` <= mem[offset]. Stays until `RD` sampled high, then goes to IDLE.
  - WCAP: registers `AD` every cycle while `WR` is low. On the edge `WR` is sampled high, writes the last registered byte to mem[offset] and goes to IDLE.
- **Unselected cycles:** stay in LATCHED with `READY`=1 and `AD` high-Z until the next `ALE`.
- **`RD` and `WR` both low:** illegal. Stay in LATCHED with no drive and no write.
- **`ALE`=1 in any state:** aborts the current cycle. The array is not written, `AD` is released, `READY` goes to 1, and the new address is latched (state LATCHED).
- **Strobe released during WAIT:** aborts to IDLE with no write. `READY` goes to 1 on the same edge.
- **Array contents:** not cleared by `RESET`. Initial contents are undefined.

## Timing
- **Reset values:** state IDLE, `READY`=1, `AD` high-Z, `Address`=20'h0, `Selected`=0, wait counter 0, write holding register 8'h00.
- **`RESET` mid-cycle:** releases `AD` and sets `READY`=1 at that edge. No array write.
- **`READY`:** low starting the cycle after the strobe is sampled low, for exactly `WAIT_STATES` cycles. It is registered, with no combinational path from `RD`/`WR`.
- **Read latency:** data valid on `AD` `WAIT_STATES`+1 cycles after the edge that sampled `RD` low. `AD` is released on the edge that samples `RD` high, so there is no drive overlap with the next `ALE` address phase.
- **Write:** the array is updated at the edge sampling `WR` high. A read of the same address in the next bus cycle returns the new byte.
- **Back-to-back cycles:** allowed. `ALE` may arrive on the cycle right after strobe release.

## Configuration
- **`I8088_RESP_WAIT_EN` defined:** WAIT state and counter are present and `READY` behaves as above.
- **`I8088_RESP_WAIT_EN` undefined:**
  - WAIT is not compiled in, `READY` is tied to 1, and `WAIT_STATES` is ignored.
  - LATCHED goes directly to DRIVE/WCAP, so read data is valid 1 cycle after `RD` is sampled low.

## Test plan
- **Reset:** `RESET` for 2 cycles with `ALE`=0 → `READY`=1, `AD`=Z, `Address`=0, `Selected`=0.
- **Write then read:** `BASE_ADDR`=20'h10000, `WAIT_STATES`=2. Write 8'hA5 to 20'h10004 (`ALE`, `IOM`=0, `WR` low for 4 cycles). Then read 20'h10004 → `READY` low for exactly 2 cycles, `AD`=8'hA5 on cycle 3 after `RD` low, `AD`=Z the cycle after `RD` high.
- **Outside window / wrong space:** read 20'h0FFFF, and read 20'h10004 with `IOM`=1 → `Selected`=0, `READY` stays 1, `AD` never driven.
- **Window edges:** write 8'h11 to 20'h10000 and 8'h22 to 20'h103FF; read both back → 8'h11 and 8'h22. Access to 20'h10400 is unselected.
- **Abort:** assert `ALE` during WAIT of a write, and `RESET` during DRIVE → no array write (read back shows the old value), `AD` released on that edge, `READY`=1.
- **Macro off:** with `I8088_RESP_WAIT_EN` undefined, `READY` is constant 1 and read data appears 1 cycle after `RD` low.
